// File: rtl/cram_loader.sv
// cram_loader: loads a word-serial bitstream into the CRAM scan chain MSB-first,
// then recirculates the chain once and compares read-back vs loaded ones-count.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for start; chain untouched
//   S_LOAD   | accepting words, shifting exactly CHAIN_LEN bits into chain
//   S_VERIFY | CHAIN_LEN loop-back shifts, counting ones at the chain tail
//   S_DONE   | one-cycle done pulse, then back to idle
module cram_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_cfg_en,
  output logic              o_cfg_dout,
  input  logic              i_cfg_din,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LP_LEN    = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LP_LEN_M1 = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] LP_WORD   = CW'(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_buf;
  logic [BW-1:0]     r_buf_cnt;
  logic [CW-1:0]     r_shifted;
  logic [CW-1:0]     r_accepted;
  logic [CW-1:0]     r_ones_ld;
  logic [CW-1:0]     r_ones_rb;
  logic [CW-1:0]     r_vcnt;
  logic              r_error;

  logic              w_shift;
  logic              w_accept;
  logic              w_load_last;
  logic              w_verify_last;
  logic [CW-1:0]     w_room;
  logic [CW-1:0]     w_take;
  logic [CW-1:0]     w_ones_rb_nxt;

  // A final word only contributes the bits that still fit in the chain.
  assign w_room        = LP_LEN - r_accepted;
  assign w_take        = (w_room < LP_WORD) ? w_room : LP_WORD;
  assign w_shift       = (r_state == S_LOAD) && (r_buf_cnt != '0);
  assign w_accept      = i_word_valid && o_word_ready;
  assign w_load_last   = w_shift && (r_shifted == LP_LEN_M1);
  assign w_verify_last = (r_state == S_VERIFY) && (r_vcnt == CW'(1));
  assign w_ones_rb_nxt = r_ones_rb + CW'(i_cfg_din);
  assign o_error       = r_error;

  // Next-state and chain/handshake outputs, all decoded from registered state.
  always_comb begin
    w_state_nxt  = r_state;
    o_word_ready = 1'b0;
    o_cfg_en     = 1'b0;
    o_cfg_dout   = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        o_busy       = 1'b1;
        // Ready while the last buffered bit goes out, so refill costs no bubble.
        o_word_ready = (r_buf_cnt <= BW'(1)) && (r_accepted < LP_LEN);
        o_cfg_en     = w_shift;
        o_cfg_dout   = r_buf[WORD_W-1];
        if (w_load_last) w_state_nxt = S_VERIFY;
      end
      S_VERIFY: begin
        o_busy     = 1'b1;
        o_cfg_en   = 1'b1;
        o_cfg_dout = i_cfg_din;
        if (w_verify_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Shift buffer, bit counters, ones-counters and sticky error.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_buf      <= '0;
      r_buf_cnt  <= '0;
      r_shifted  <= '0;
      r_accepted <= '0;
      r_ones_ld  <= '0;
      r_ones_rb  <= '0;
      r_vcnt     <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_buf_cnt  <= '0;
            r_shifted  <= '0;
            r_accepted <= '0;
            r_ones_ld  <= '0;
            r_ones_rb  <= '0;
            r_error    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_buf      <= i_word_data;
            r_buf_cnt  <= BW'(w_take);
            r_accepted <= r_accepted + w_take;
          end else if (w_shift) begin
            r_buf     <= {r_buf[WORD_W-2:0], 1'b0};
            r_buf_cnt <= r_buf_cnt - BW'(1);
          end
          if (w_shift) begin
            r_shifted <= r_shifted + CW'(1);
            r_ones_ld <= r_ones_ld + CW'(r_buf[WORD_W-1]);
          end
          if (w_load_last) r_vcnt <= LP_LEN;
        end
        S_VERIFY: begin
          r_ones_rb <= w_ones_rb_nxt;
          r_vcnt    <= r_vcnt - CW'(1);
          if (w_verify_last) r_error <= (w_ones_rb_nxt != r_ones_ld);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cram_loader.sv
// Bench for cram_loader: two DUTs (48-bit and 44-bit chains) against
// shift-register chain models, with a bit scoreboard on the load stream.
`timescale 1ns/1ps
module tb_cram_loader;

  typedef struct packed {
    bit        sel;       // 0: 48-bit DUT, 1: 44-bit DUT
    bit [47:0] words;     // six words, first word in the top byte
    bit [7:0]  gap;       // valid-low cycles after the 2nd accept
    bit        stuck;     // chain tail stuck-at-0 during verify
    bit        vstart;    // pulse start in the middle of verify
    bit        prev_err;  // error level expected before this start
    bit [47:0] exp_chain;
    bit        exp_err;
    bit [7:0]  exp_gaps;
  } vec_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic word_valid = 1'b0;
  logic [7:0] word_data = 8'h00;
  logic stuck_en = 1'b0;
  logic vphase = 1'b0;

  logic rdy_a, en_a, dout_a, din_a, busy_a, done_a, err_a;
  logic rdy_b, en_b, dout_b, din_b, busy_b, done_b, err_b;
  logic w_ready, w_en, w_dout, w_busy, w_done, w_err;
  logic [47:0] chain_a = '0;
  logic [43:0] chain_b = '0;

  always #0.05 clk = ~clk;

  cram_loader #(.CHAIN_LEN(48), .WORD_W(8)) u_dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_start(start & ~sel),
    .i_word_data(word_data), .i_word_valid(word_valid & ~sel),
    .o_word_ready(rdy_a), .o_cfg_en(en_a), .o_cfg_dout(dout_a),
    .i_cfg_din(din_a), .o_busy(busy_a), .o_done(done_a), .o_error(err_a));

  cram_loader #(.CHAIN_LEN(44), .WORD_W(8)) u_dut_b (
    .i_clk(clk), .i_nrst(nrst), .i_start(start & sel),
    .i_word_data(word_data), .i_word_valid(word_valid & sel),
    .o_word_ready(rdy_b), .o_cfg_en(en_b), .o_cfg_dout(dout_b),
    .i_cfg_din(din_b), .o_busy(busy_b), .o_done(done_b), .o_error(err_b));

  assign din_a   = (stuck_en && vphase) ? 1'b0 : chain_a[47];
  assign din_b   = chain_b[43];
  assign w_ready = sel ? rdy_b  : rdy_a;
  assign w_en    = sel ? en_b   : en_a;
  assign w_dout  = sel ? dout_b : dout_a;
  assign w_busy  = sel ? busy_b : busy_a;
  assign w_done  = sel ? done_b : done_a;
  assign w_err   = sel ? err_b  : err_a;

  // chain models: shift toward the tail on each enabled edge
  always @(posedge clk) begin
    if (en_a) chain_a <= {chain_a[46:0], dout_a};
    if (en_b) chain_b <= {chain_b[42:0], dout_b};
  end

  int total = 0;
  int bad = 0;
  bit exp_q[$];
  bit [7:0] wq[$];
  int len, pushed, en_cnt, gaps, lat, done_cnt, acc_words, ready_after;
  int since_start, gap_left, gap_cfg;
  bit err_at_done, done_after_en, prev_en;
  logic [47:0] chain_at_done;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // one clock: observe at negedge, drive new inputs just after posedge
  task automatic step();
    bit b;
    @(negedge clk);
    if (w_ready && acc_words >= 6) ready_after++;
    if (word_valid && w_ready) begin
      acc_words++;
      for (int i = 7; i >= 0; i--)
        if (pushed < len) begin
          exp_q.push_back(word_data[i]);
          pushed++;
        end
      if (wq.size() > 0) void'(wq.pop_front());
      if (acc_words == 2 && gap_cfg > 0) gap_left = gap_cfg;
    end
    if (w_en) begin
      if (en_cnt < len) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: cfg_en with no expected bit, en_cnt=%0d", en_cnt);
        end else begin
          b = exp_q.pop_front();
          chk("sb_bit", 48'(w_dout), 48'(b));
        end
      end
      if (lat < 0) lat = since_start;
      en_cnt++;
    end else if (en_cnt > 0 && en_cnt < len) begin
      gaps++;
    end
    if (w_done) begin
      done_cnt++;
      if (done_cnt == 1) begin
        err_at_done   = w_err;
        chain_at_done = sel ? {4'h0, chain_b} : chain_a;
        done_after_en = prev_en;
      end
    end
    vphase = (en_cnt >= len);
    prev_en = w_en;
    since_start++;
    @(posedge clk);
    #0.01;
    word_valid = (wq.size() > 0) && (gap_left == 0);
    word_data  = (wq.size() > 0) ? wq[0] : 8'h00;
    if (gap_left > 0) gap_left--;
  endtask

  task automatic prep(input vec_t v);
    sel = v.sel;
    len = v.sel ? 44 : 48;
    gap_cfg = int'(v.gap);
    stuck_en = v.stuck;
    wq.delete();
    exp_q.delete();
    for (int k = 0; k < 6; k++) wq.push_back(v.words[47-8*k -: 8]);
    pushed = 0; en_cnt = 0; gaps = 0; lat = -1; done_cnt = 0; acc_words = 0;
    ready_after = 0; gap_left = 0; vphase = 1'b0; prev_en = 1'b0;
    since_start = 0; err_at_done = 1'b0; done_after_en = 1'b0; chain_at_done = '0;
  endtask

  task automatic kick();
    start = 1'b1;
    word_valid = 1'b1;
    word_data = wq[0];
    since_start = 0;
    step();
    start = 1'b0;
  endtask

  task automatic run_case(input int idx, input vec_t v);
    prep(v);
    step();
    step();
    chk($sformatf("c%0d_err_before", idx), 48'(w_err), 48'(v.prev_err));
    kick();
    step();
    chk($sformatf("c%0d_busy", idx), 48'(w_busy), 48'd1);
    chk($sformatf("c%0d_err_cleared", idx), 48'(w_err), 48'd0);
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      step();
      start = (v.vstart && en_cnt == len + 10) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("FAIL c%0d_timeout: no done within 400 cycles, en_cnt=%0d", idx, en_cnt);
    end
    repeat (6) step();
    chk($sformatf("c%0d_chain", idx), chain_at_done, v.exp_chain);
    chk($sformatf("c%0d_error", idx), 48'(err_at_done), 48'(v.exp_err));
    chk($sformatf("c%0d_en_cycles", idx), 48'(en_cnt), 48'(2 * len));
    chk($sformatf("c%0d_gaps", idx), 48'(gaps), 48'(v.exp_gaps));
    chk($sformatf("c%0d_latency", idx), 48'(lat), 48'd2);
    chk($sformatf("c%0d_done_pulses", idx), 48'(done_cnt), 48'd1);
    chk($sformatf("c%0d_done_after_en", idx), 48'(done_after_en), 48'd1);
    chk($sformatf("c%0d_words", idx), 48'(acc_words), 48'd6);
    chk($sformatf("c%0d_ready_after_last", idx), 48'(ready_after), 48'd0);
    chk($sformatf("c%0d_sb_left", idx), 48'(exp_q.size()), 48'd0);
    chk($sformatf("c%0d_idle", idx), 48'(w_busy), 48'd0);
  endtask

  initial begin
    tbl[0] = '{sel:1'b0, words:48'hA53CFF00817E, gap:8'd0, stuck:1'b0, vstart:1'b0,
               prev_err:1'b0, exp_chain:48'hA53CFF00817E, exp_err:1'b0, exp_gaps:8'd0};
    tbl[1] = '{sel:1'b0, words:48'hA53CFF00817E, gap:8'd12, stuck:1'b0, vstart:1'b0,
               prev_err:1'b0, exp_chain:48'hA53CFF00817E, exp_err:1'b0, exp_gaps:8'd5};
    tbl[2] = '{sel:1'b1, words:48'hA53CFF0081FF, gap:8'd0, stuck:1'b0, vstart:1'b0,
               prev_err:1'b0, exp_chain:48'h0A53CFF0081F, exp_err:1'b0, exp_gaps:8'd0};
    tbl[3] = '{sel:1'b0, words:48'hA53CFF00817E, gap:8'd0, stuck:1'b1, vstart:1'b0,
               prev_err:1'b0, exp_chain:48'h000000000000, exp_err:1'b1, exp_gaps:8'd0};
    tbl[4] = '{sel:1'b0, words:48'h000000000000, gap:8'd0, stuck:1'b0, vstart:1'b0,
               prev_err:1'b1, exp_chain:48'h000000000000, exp_err:1'b0, exp_gaps:8'd0};
    tbl[5] = '{sel:1'b0, words:48'h123456789ABC, gap:8'd0, stuck:1'b0, vstart:1'b1,
               prev_err:1'b0, exp_chain:48'h123456789ABC, exp_err:1'b0, exp_gaps:8'd0};

    #0.02 nrst = 1'b0;
    #0.01;
    chk("rst_ready", 48'(rdy_a), 48'd0);
    chk("rst_cfg_en", 48'(en_a), 48'd0);
    chk("rst_cfg_dout", 48'(dout_a), 48'd0);
    chk("rst_busy", 48'(busy_a), 48'd0);
    chk("rst_done", 48'(done_a), 48'd0);
    chk("rst_error", 48'(err_a), 48'd0);
    chk("rst_b_cfg_en", 48'(en_b), 48'd0);
    prep(tbl[0]);
    step();
    nrst = 1'b1;

    for (int i = 0; i < 6; i++) run_case(i, tbl[i]);

    // reset asserted in the middle of a load
    prep(tbl[0]);
    step();
    kick();
    for (int k = 0; k < 100 && en_cnt < 20; k++) step();
    chk("midrst_reached_20", 48'(en_cnt), 48'd20);
    nrst = 1'b0;
    #0.01;
    chk("midrst_cfg_en", 48'(en_a), 48'd0);
    chk("midrst_busy", 48'(busy_a), 48'd0);
    chk("midrst_ready", 48'(rdy_a), 48'd0);
    step();
    step();
    chk("midrst_hold_cfg_en", 48'(en_a), 48'd0);
    nrst = 1'b1;
    run_case(6, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
